// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with step/redirect/stall/call/ret; optional return-address stack via PC_SEQ_RAS_EN
module pc_sequencer #(
  parameter int WIDTH = 21,
  parameter int STEP = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_target,
  input  logic                         call,
  input  logic [WIDTH-1:0]             call_target,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pc_plus,
  output logic                         ret_miss,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);
  logic             has;
  logic [WIDTH-1:0] top;
  assign pc_plus = pc_out + WIDTH'(STEP);
`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  assign top_idx = ptr - 1'b1;
  assign has     = ras_count != '0;
  assign top     = ras[top_idx];
  // circular stack: push overwrites oldest when full, tail call rewrites top in place
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      ras_count <= '0;
    end else if (!redirect_valid && !stall) begin
      if (call && ret && has) ras[top_idx] <= pc_plus;
      else if (call) begin
        ras[ptr]  <= pc_plus;
        ptr       <= ptr + 1'b1;
        ras_count <= (ras_count == CW'(RAS_DEPTH)) ? ras_count : ras_count + 1'b1;
      end else if (ret && has) begin
        ptr       <= top_idx;
        ras_count <= ras_count - 1'b1;
      end
    end
  end
`else
  assign has       = 1'b0;
  assign top       = '0;
  assign ras_count = '0;
`endif
  // PC update with priority reset > redirect > stall > call/ret > sequential
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out   <= RESET_VECTOR;
      ret_miss <= 1'b0;
    end else if (redirect_valid) begin
      pc_out   <= redirect_target;
      ret_miss <= 1'b0;
    end else if (stall) begin
      ret_miss <= 1'b0;
    end else begin
      pc_out   <= call ? call_target : (ret && has) ? top : pc_plus;
      ret_miss <= ret && !call && !has;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer with or without PC_SEQ_RAS_EN
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [20:0] redirect_target = '0;
  logic [20:0] call_target = '0;
  logic [20:0] pc_out;
  logic [20:0] pc_plus;
  logic        ret_miss;
  logic [2:0]  ras_count;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pc_sequencer #(.WIDTH(21), .STEP(4), .RESET_VECTOR(21'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .call(call), .call_target(call_target),
    .ret(ret), .pc_out(pc_out), .pc_plus(pc_plus), .ret_miss(ret_miss),
    .ras_count(ras_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic st, input logic rv, input logic [20:0] rt,
                      input logic c, input logic [20:0] ct, input logic r);
    stall = st;
    redirect_valid = rv;
    redirect_target = rt;
    call = c;
    call_target = ct;
    ret = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_out, 0);
    check("rst_cnt", ras_count, 0);
    check("rst_miss", ret_miss, 0);
    check("rst_plus", pc_plus, 4);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0, 0); check("idle1", pc_out, 4);
    tick(0, 0, 0, 0, 0, 0); check("idle2", pc_out, 8);
    tick(1, 0, 0, 0, 0, 0); check("stall1", pc_out, 8);
    tick(1, 0, 0, 0, 0, 0); check("stall2", pc_out, 8);
    tick(1, 1, 100, 0, 0, 0); check("redir_stall", pc_out, 100);
    check("redir_plus", pc_plus, 104);
    tick(0, 1, 21'h40, 0, 0, 0); check("redir40", pc_out, 32'h40);
    tick(0, 0, 0, 1, 21'h200, 0); check("call_pc", pc_out, 32'h200);
    check("call_cnt", ras_count, RAS ? 1 : 0);
    tick(1, 0, 0, 0, 0, 1); check("stall_ret_pc", pc_out, 32'h200);
    check("stall_ret_cnt", ras_count, RAS ? 1 : 0);
    check("stall_ret_miss", ret_miss, 0);
    tick(0, 0, 0, 0, 0, 0); check("body1", pc_out, 32'h204);
    tick(0, 0, 0, 0, 0, 0); check("body2", pc_out, 32'h208);
    tick(0, 0, 0, 0, 0, 0); check("body3", pc_out, 32'h20C);
    tick(0, 0, 0, 0, 0, 1); check("ret_pc", pc_out, RAS ? 32'h44 : 32'h210);
    check("ret_cnt", ras_count, 0);
    check("ret_miss", ret_miss, RAS ? 0 : 1);
    tick(0, 0, 0, 0, 0, 0); check("miss_clear", ret_miss, 0);
    tick(0, 1, 21'h100, 0, 0, 0);
    tick(0, 0, 0, 1, 21'h200, 0); check("tc_call", pc_out, 32'h200);
    tick(0, 0, 0, 1, 21'h300, 1); check("tail_pc", pc_out, 32'h300);
    check("tail_cnt", ras_count, RAS ? 1 : 0);
    check("tail_miss", ret_miss, 0);
    tick(0, 0, 0, 0, 0, 1); check("tail_ret_pc", pc_out, RAS ? 32'h204 : 32'h304);
    check("tail_ret_miss", ret_miss, RAS ? 0 : 1);
    check("tail_ret_cnt", ras_count, 0);
    tick(0, 1, 21'h600, 1, 21'h700, 1); check("redir_over_call", pc_out, 32'h600);
    check("redir_over_cnt", ras_count, 0);
    check("redir_over_miss", ret_miss, 0);
`ifdef PC_SEQ_RAS_EN
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, 21'((i + 1) * 16), 0);
      check("nest_call", pc_out, (i + 1) * 16);
    end
    check("nest_full", ras_count, 4);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0, 1);
      check("nest_ret", pc_out, 32'h44 - i * 16);
      check("nest_miss", ret_miss, 0);
    end
    tick(0, 0, 0, 0, 0, 1);
    check("nest_ret5", pc_out, 32'h18);
    check("nest_miss5", ret_miss, 1);
    check("nest_cnt5", ras_count, 0);
`endif
    tick(0, 1, 21'h1FFFFC, 0, 0, 0); check("wrap_pc", pc_out, 32'h1FFFFC);
    check("wrap_plus", pc_plus, 0);
    tick(0, 0, 0, 0, 0, 0); check("wrap_zero", pc_out, 0);
    tick(0, 0, 0, 1, 21'h500, 0); check("pre_rst_cnt", ras_count, RAS ? 1 : 0);
    rst = 1'b1;
    tick(0, 0, 0, 1, 21'h700, 0); check("mid_rst_pc", pc_out, 0);
    check("mid_rst_cnt", ras_count, 0);
    rst = 1'b0;
    tick(0, 0, 0, 1, 21'h80, 0); check("c80_pc", pc_out, 32'h80);
    check("c80_cnt", ras_count, RAS ? 1 : 0);
    tick(0, 0, 0, 0, 0, 1); check("r80_pc", pc_out, RAS ? 32'h4 : 32'h84);
    check("r80_miss", ret_miss, RAS ? 0 : 1);
    check("r80_cnt", ras_count, 0);
    tick(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
